axil_addr_decoder: RTL and testbench
====================================

Name: axil_addr_decoder

Overview:
- 1-master to N-slave AXI-Lite address decoder. It sits directly upstream of the bus endpoints and feeds them.
- Each transaction is routed to the slave whose base/mask window matches the address.
- Unmapped addresses are terminated internally with DECERR (2'b11), so no slave is involved.
- Write and read paths are independent. Each path allows one outstanding transaction.

Parameters:
- N_SLAVES, 4, number of downstream slave ports (1..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width (32 or 64).
- BASE_ADDR, {N_SLAVES{32'h0}}, flattened N_SLAVES*ADDR_W; entry i is the base of slave i.
- ADDR_MASK, {N_SLAVES{32'h0}}, flattened N_SLAVES*ADDR_W; the set bits are compared for slave i.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- areset  in  1  synchronous, active-high reset.
- m_awValid/m_awReady  in/out  1  master write-address handshake.
- m_awAddr  in  ADDR_W  write address.
- m_awProt  in  3  write protection.
- m_wValid/m_wReady  in/out  1  master write-data handshake.
- m_wData  in  DATA_W  write data.
- m_wStrb  in  DATA_W/8  write strobes.
- m_bValid/m_bReady  out/in  1  write response handshake.
- m_bResp  out  2  write response.
- m_arValid/m_arReady  in/out  1  master read-address handshake.
- m_arAddr  in  ADDR_W  read address.
- m_arProt  in  3  read protection.
- m_rValid/m_rReady  out/in  1  read data handshake.
- m_rData  out  DATA_W  read data.
- m_rResp  out  2  read response.
- s_awValid/s_awReady  out/in  N_SLAVES  per-slave write-address handshake.
- s_awAddr, s_awProt  out  ADDR_W, 3  broadcast to all slaves.
- s_wValid/s_wReady  out/in  N_SLAVES  per-slave write-data handshake.
- s_wData, s_wStrb  out  DATA_W, DATA_W/8  broadcast.
- s_bValid/s_bReady  in/out  N_SLAVES  per-slave write-response handshake.
- s_bResp  in  N_SLAVES*2  per-slave response; slice i belongs to slave i.
- s_arValid/s_arReady  out/in  N_SLAVES  per-slave read-address handshake.
- s_arAddr, s_arProt  out  ADDR_W, 3  broadcast.
- s_rValid/s_rReady  in/out  N_SLAVES  per-slave read handshake.
- s_rData  in  N_SLAVES*DATA_W  per-slave read data.
- s_rResp  in  N_SLAVES*2  per-slave read response.

Behaviour:
- Decode:
  - hit[i] = ((addr ^ BASE_ADDR[i]) & ADDR_MASK[i]) == 0.
  - The lowest hitting index wins.
  - No hit means MISS.
  - The address is forwarded unmodified.
- Registered outputs: every valid, ready, address, data and response output is a register. No combinational in-to-out paths.
- Reset state, held while areset=1:
  - all valid and ready outputs are 0.
  - m_bResp, m_rResp and m_rData are 0.
  - both FSMs are in IDLE.
  - m_awReady and m_arReady rise on the first clock after areset falls.
- Write FSM:
  - W_IDLE: m_awReady=1. On AW handshake: latch addr and prot, latch the decode result, then m_awReady=0 and go to W_DATA.
  - W_DATA: m_wReady=1. On W handshake: latch data and strb.
    - If MISS: go to W_RESP with bResp=2'b11.
    - Otherwise: go to W_SLV.
  - W_SLV: assert s_awValid[sel] and s_wValid[sel].
    - Each valid is held until its own handshake, then drops. Per-channel done flags allow AW and W to be accepted in either order or in the same cycle.
    - When both are done, go to W_BWAIT.
  - W_BWAIT: s_bReady[sel]=1. On s_bValid[sel]: latch the s_bResp slice and go to W_RESP.
  - W_RESP: m_bValid=1 with m_bResp stable until m_bReady. Then go to W_IDLE, where m_awReady=1 on the next cycle.
- Read FSM:
  - R_IDLE: m_arReady=1. On AR handshake: latch addr, prot and decode.
    - If MISS: go to R_RESP with rResp=2'b11 and rData=0.
    - Otherwise: go to R_SLV.
  - R_SLV: s_arValid[sel]=1 until the handshake, then go to R_WAIT.
  - R_WAIT: s_rReady[sel]=1. On s_rValid[sel]: latch the data and resp slices and go to R_RESP.
  - R_RESP: m_rValid=1 with data and resp stable until m_rReady. Then go to R_IDLE.
- Non-selected slaves never see valid or ready asserted.
- Inputs from non-selected slaves are ignored.
- The read and write FSMs run concurrently, including to the same slave.
- Miss latency:
  - Write: AW handshake at cycle 0, W accepted cycle 1 or later, m_bValid the cycle after the W handshake.
  - Read: m_rValid 2 cycles after the AR handshake.
- Reset mid-transaction: all in-flight state is discarded and all valids drop in the reset cycle. Slaves are not waited on.
- Response values from slaves are passed through unchanged, including SLVERR.

Test Plan:
- N_SLAVES=2, BASE={0x1000,0x0000}, MASK={0xF000,0xF000}: write 0x1004 data 0xDEADBEEF -> only s_awValid[1]/s_wValid[1] assert with addr 0x1004; slave bResp=00 -> m_bResp=00.
- Read of 0x5000 (miss) -> no s_arValid; m_rValid 2 cycles after AR handshake, m_rResp=2'b11, m_rData=0.
- Write to slave 0 with s_wReady[0] one cycle before s_awReady[0] -> both accepted once each, single m_bValid pulse.
- m_rReady held low 5 cycles in R_RESP -> m_rValid, m_rData and m_rResp stable all 5 cycles; m_arReady stays 0.
- Concurrent write to slave 1 and read from slave 0, started the same cycle -> both complete independently with correct responses.
- areset=1 while in W_BWAIT -> next cycle all valids and readies are 0; after release m_awReady=1 and a fresh write completes normally.

Source files
------------

// File: rtl/axil_addr_decoder.sv
// Purpose : 1-master to N-slave AXI-Lite address decoder; unmapped addresses get DECERR locally.
// Latency : write miss B one cycle after W; read miss R two cycles after AR; hits add slave latency.
// Backpres: one outstanding transaction per path; every output is a register, so no comb paths.
// Ports   : aclk/areset (sync, active-high); m_* master-side AW/W/B/AR/R; s_* per-slave valid/ready
//           vectors, broadcast addr/prot/data/strb, and flattened per-slave response/data slices.
module axil_addr_decoder #(
  parameter int                          N_SLAVES  = 4,
  parameter int                          ADDR_W    = 32,
  parameter int                          DATA_W    = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0]  BASE_ADDR = '0,
  parameter logic [N_SLAVES*ADDR_W-1:0]  ADDR_MASK = '0
) (
  input  logic                         aclk,
  input  logic                         areset,
  // master write
  input  logic                         m_awValid,
  output logic                         m_awReady,
  input  logic [ADDR_W-1:0]            m_awAddr,
  input  logic [2:0]                   m_awProt,
  input  logic                         m_wValid,
  output logic                         m_wReady,
  input  logic [DATA_W-1:0]            m_wData,
  input  logic [DATA_W/8-1:0]          m_wStrb,
  output logic                         m_bValid,
  input  logic                         m_bReady,
  output logic [1:0]                   m_bResp,
  // master read
  input  logic                         m_arValid,
  output logic                         m_arReady,
  input  logic [ADDR_W-1:0]            m_arAddr,
  input  logic [2:0]                   m_arProt,
  output logic                         m_rValid,
  input  logic                         m_rReady,
  output logic [DATA_W-1:0]            m_rData,
  output logic [1:0]                   m_rResp,
  // slave write
  output logic [N_SLAVES-1:0]          s_awValid,
  input  logic [N_SLAVES-1:0]          s_awReady,
  output logic [ADDR_W-1:0]            s_awAddr,
  output logic [2:0]                   s_awProt,
  output logic [N_SLAVES-1:0]          s_wValid,
  input  logic [N_SLAVES-1:0]          s_wReady,
  output logic [DATA_W-1:0]            s_wData,
  output logic [DATA_W/8-1:0]          s_wStrb,
  input  logic [N_SLAVES-1:0]          s_bValid,
  output logic [N_SLAVES-1:0]          s_bReady,
  input  logic [N_SLAVES*2-1:0]        s_bResp,
  // slave read
  output logic [N_SLAVES-1:0]          s_arValid,
  input  logic [N_SLAVES-1:0]          s_arReady,
  output logic [ADDR_W-1:0]            s_arAddr,
  output logic [2:0]                   s_arProt,
  input  logic [N_SLAVES-1:0]          s_rValid,
  output logic [N_SLAVES-1:0]          s_rReady,
  input  logic [N_SLAVES*DATA_W-1:0]   s_rData,
  input  logic [N_SLAVES*2-1:0]        s_rResp
);

  localparam int SEL_W  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {W_IDLE, W_DATA, W_SLV, W_BWAIT, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_SLV, R_WAIT, R_RESP} rstate_t;

  // Returns {miss, index}. Scanning from the top down lets the lowest hit overwrite.
  function automatic logic [SEL_W:0] f_decode(input logic [ADDR_W-1:0] addr);
    logic [SEL_W:0] res;
    res = {1'b1, {SEL_W{1'b0}}};
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (((addr ^ BASE_ADDR[i*ADDR_W +: ADDR_W]) & ADDR_MASK[i*ADDR_W +: ADDR_W]) == '0)
        res = {1'b0, SEL_W'(i)};
    end
    return res;
  endfunction

  // write path state
  wstate_t               r_wstate;
  logic                  r_awready, r_wready, r_bvalid;
  logic [1:0]            r_bresp;
  logic [SEL_W-1:0]      r_wsel;
  logic                  r_wmiss;
  logic                  r_aw_done, r_w_done;
  logic [N_SLAVES-1:0]   r_saw_valid, r_sw_valid, r_sb_ready;
  logic [ADDR_W-1:0]     r_saw_addr;
  logic [2:0]            r_saw_prot;
  logic [DATA_W-1:0]     r_sw_data;
  logic [STRB_W-1:0]     r_sw_strb;

  // read path state
  rstate_t               r_rstate;
  logic                  r_arready, r_rvalid;
  logic [1:0]            r_rresp;
  logic [DATA_W-1:0]     r_rdata;
  logic [SEL_W-1:0]      r_rsel;
  logic [N_SLAVES-1:0]   r_sar_valid, r_sr_ready;
  logic [ADDR_W-1:0]     r_sar_addr;
  logic [2:0]            r_sar_prot;

  logic [SEL_W:0]        w_aw_dec, w_ar_dec;
  logic [N_SLAVES-1:0]   w_wsel_oh, w_rsel_oh, w_ar_oh;
  logic                  w_aw_hs, w_w_hs;
  logic [1:0]            w_bresp_sel, w_rresp_sel;
  logic [DATA_W-1:0]     w_rdata_sel;

  assign w_aw_dec  = f_decode(m_awAddr);
  assign w_ar_dec  = f_decode(m_arAddr);
  assign w_wsel_oh = N_SLAVES'(1) << r_wsel;
  assign w_rsel_oh = N_SLAVES'(1) << r_rsel;
  assign w_ar_oh   = N_SLAVES'(1) << w_ar_dec[SEL_W-1:0];
  // Only the selected bit of the valid vectors is ever set, so this masks off other slaves.
  assign w_aw_hs   = |(r_saw_valid & s_awReady);
  assign w_w_hs    = |(r_sw_valid & s_wReady);

  // Response/data muxes driven by the latched selection; unselected slices are ignored.
  always_comb begin
    w_bresp_sel = '0;
    w_rresp_sel = '0;
    w_rdata_sel = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (r_wsel == SEL_W'(i)) w_bresp_sel = s_bResp[i*2 +: 2];
      if (r_rsel == SEL_W'(i)) begin
        w_rresp_sel = s_rResp[i*2 +: 2];
        w_rdata_sel = s_rData[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wstate    <= W_IDLE;
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bresp     <= 2'b00;
      r_wsel      <= '0;
      r_wmiss     <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_saw_valid <= '0;
      r_sw_valid  <= '0;
      r_sb_ready  <= '0;
      r_saw_addr  <= '0;
      r_saw_prot  <= '0;
      r_sw_data   <= '0;
      r_sw_strb   <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (m_awValid && r_awready) begin
            r_awready  <= 1'b0;
            r_wready   <= 1'b1;
            r_saw_addr <= m_awAddr;
            r_saw_prot <= m_awProt;
            r_wsel     <= w_aw_dec[SEL_W-1:0];
            r_wmiss    <= w_aw_dec[SEL_W];
            r_wstate   <= W_DATA;
          end
        end
        W_DATA: begin
          if (m_wValid && r_wready) begin
            r_wready  <= 1'b0;
            r_sw_data <= m_wData;
            r_sw_strb <= m_wStrb;
            if (r_wmiss) begin
              r_bvalid <= 1'b1;
              r_bresp  <= 2'b11;
              r_wstate <= W_RESP;
            end else begin
              r_saw_valid <= w_wsel_oh;
              r_sw_valid  <= w_wsel_oh;
              r_aw_done   <= 1'b0;
              r_w_done    <= 1'b0;
              r_wstate    <= W_SLV;
            end
          end
        end
        W_SLV: begin
          // AW and W complete independently, in either order or together.
          if (w_aw_hs) begin
            r_saw_valid <= '0;
            r_aw_done   <= 1'b1;
          end
          if (w_w_hs) begin
            r_sw_valid <= '0;
            r_w_done   <= 1'b1;
          end
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
            r_sb_ready <= w_wsel_oh;
            r_wstate   <= W_BWAIT;
          end
        end
        W_BWAIT: begin
          if (s_bValid[r_wsel]) begin
            r_sb_ready <= '0;
            r_bresp    <= w_bresp_sel;
            r_bvalid   <= 1'b1;
            r_wstate   <= W_RESP;
          end
        end
        W_RESP: begin
          if (m_bReady) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rstate    <= R_IDLE;
      r_arready   <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rresp     <= 2'b00;
      r_rdata     <= '0;
      r_rsel      <= '0;
      r_sar_valid <= '0;
      r_sr_ready  <= '0;
      r_sar_addr  <= '0;
      r_sar_prot  <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (m_arValid && r_arready) begin
            r_arready  <= 1'b0;
            r_sar_addr <= m_arAddr;
            r_sar_prot <= m_arProt;
            r_rsel     <= w_ar_dec[SEL_W-1:0];
            if (w_ar_dec[SEL_W]) begin
              r_rdata  <= '0;
              r_rresp  <= 2'b11;
              r_rstate <= R_RESP;
            end else begin
              r_sar_valid <= w_ar_oh;
              r_rstate    <= R_SLV;
            end
          end
        end
        R_SLV: begin
          if (|(r_sar_valid & s_arReady)) begin
            r_sar_valid <= '0;
            r_sr_ready  <= w_rsel_oh;
            r_rstate    <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (s_rValid[r_rsel]) begin
            r_sr_ready <= '0;
            r_rdata    <= w_rdata_sel;
            r_rresp    <= w_rresp_sel;
            r_rstate   <= R_RESP;
          end
        end
        R_RESP: begin
          // rValid rises one cycle after entry, giving the two-cycle miss latency.
          if (!r_rvalid) begin
            r_rvalid <= 1'b1;
          end else if (m_rReady) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign m_awReady = r_awready;
  assign m_wReady  = r_wready;
  assign m_bValid  = r_bvalid;
  assign m_bResp   = r_bresp;
  assign m_arReady = r_arready;
  assign m_rValid  = r_rvalid;
  assign m_rData   = r_rdata;
  assign m_rResp   = r_rresp;
  assign s_awValid = r_saw_valid;
  assign s_awAddr  = r_saw_addr;
  assign s_awProt  = r_saw_prot;
  assign s_wValid  = r_sw_valid;
  assign s_wData   = r_sw_data;
  assign s_wStrb   = r_sw_strb;
  assign s_bReady  = r_sb_ready;
  assign s_arValid = r_sar_valid;
  assign s_arAddr  = r_sar_addr;
  assign s_arProt  = r_sar_prot;
  assign s_rReady  = r_sr_ready;

endmodule

// File: tb/tb_axil_addr_decoder.sv
// Purpose : directed table-driven bench for axil_addr_decoder with two slaves.
// Latency : checks miss latencies and response timing cycle by cycle.
// Backpres: exercises slave handshake ordering, master response stalls and mid-transaction reset.
module tb_axil_addr_decoder;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TMO = 100;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic m_awValid = 0, m_awReady;  logic [AW-1:0] m_awAddr = '0; logic [2:0] m_awProt = '0;
  logic m_wValid = 0, m_wReady;    logic [DW-1:0] m_wData = '0;  logic [DW/8-1:0] m_wStrb = '0;
  logic m_bValid, m_bReady = 0;    logic [1:0] m_bResp;
  logic m_arValid = 0, m_arReady;  logic [AW-1:0] m_arAddr = '0; logic [2:0] m_arProt = '0;
  logic m_rValid, m_rReady = 0;    logic [DW-1:0] m_rData;       logic [1:0] m_rResp;
  logic [N-1:0] s_awValid, s_awReady = '0, s_wValid, s_wReady = '0;
  logic [AW-1:0] s_awAddr, s_arAddr; logic [2:0] s_awProt, s_arProt;
  logic [DW-1:0] s_wData; logic [DW/8-1:0] s_wStrb;
  logic [N-1:0] s_bValid = '0, s_bReady; logic [N*2-1:0] s_bResp = '0;
  logic [N-1:0] s_arValid, s_arReady = '0, s_rValid = '0, s_rReady;
  logic [N*DW-1:0] s_rData = '0; logic [N*2-1:0] s_rResp = '0;

  int n_tests = 0;
  int n_fail  = 0;

  axil_addr_decoder #(
    .N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW),
    .BASE_ADDR({32'h0000_1000, 32'h0000_0000}),
    .ADDR_MASK({32'h0000_F000, 32'h0000_F000})
  ) dut (
    .aclk(aclk), .areset(areset),
    .m_awValid(m_awValid), .m_awReady(m_awReady), .m_awAddr(m_awAddr), .m_awProt(m_awProt),
    .m_wValid(m_wValid), .m_wReady(m_wReady), .m_wData(m_wData), .m_wStrb(m_wStrb),
    .m_bValid(m_bValid), .m_bReady(m_bReady), .m_bResp(m_bResp),
    .m_arValid(m_arValid), .m_arReady(m_arReady), .m_arAddr(m_arAddr), .m_arProt(m_arProt),
    .m_rValid(m_rValid), .m_rReady(m_rReady), .m_rData(m_rData), .m_rResp(m_rResp),
    .s_awValid(s_awValid), .s_awReady(s_awReady), .s_awAddr(s_awAddr), .s_awProt(s_awProt),
    .s_wValid(s_wValid), .s_wReady(s_wReady), .s_wData(s_wData), .s_wStrb(s_wStrb),
    .s_bValid(s_bValid), .s_bReady(s_bReady), .s_bResp(s_bResp),
    .s_arValid(s_arValid), .s_arReady(s_arReady), .s_arAddr(s_arAddr), .s_arProt(s_arProt),
    .s_rValid(s_rValid), .s_rReady(s_rReady), .s_rData(s_rData), .s_rResp(s_rResp)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name, input int n);
    n_tests++;
    if (n >= TMO) begin
      n_fail++;
      $display("FAIL %s: waited %0d cycles, required under %0d", name, n, TMO);
    end
  endtask

  task automatic send_aw(input logic [AW-1:0] addr);
    int n;
    m_awAddr = addr; m_awProt = 3'b010; m_awValid = 1'b1;
    n = 0;
    while (!m_awReady && n < TMO) begin step(); n++; end
    tmo("aw_ready_wait", n);
    step();
    m_awValid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] data);
    int n;
    m_wData = data; m_wStrb = 4'hF; m_wValid = 1'b1;
    n = 0;
    while (!m_wReady && n < TMO) begin step(); n++; end
    tmo("w_ready_wait", n);
    step();
    m_wValid = 1'b0;
  endtask

  // slv < 0 means the address is expected to miss.
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int slv,
                          input logic [1:0] sresp, input logic [1:0] eresp);
    logic [N-1:0] oh;
    int n;
    oh = (slv >= 0) ? (N'(1) << slv) : '0;
    send_aw(addr);
    send_w(data);
    if (slv < 0) begin
      chk("wr_miss_bvalid_latency", m_bValid, 1);
      chk("wr_miss_no_slave_valid", {s_awValid, s_wValid}, 0);
    end else begin
      chk("wr_s_awValid", s_awValid, oh);
      chk("wr_s_wValid", s_wValid, oh);
      chk("wr_s_awAddr", s_awAddr, addr);
      chk("wr_s_awProt", s_awProt, 3'b010);
      chk("wr_s_wData", s_wData, data);
      s_awReady = oh; s_wReady = oh;
      step();
      s_awReady = '0; s_wReady = '0;
      chk("wr_s_valid_drop", {s_awValid, s_wValid}, 0);
      n = 0;
      while (s_bReady !== oh && n < TMO) begin step(); n++; end
      tmo("wr_s_bReady_wait", n);
      // Both slaves assert bValid with distinct responses; only the selected slice may pass.
      s_bValid = '1; s_bResp = 4'b0101; s_bResp[slv*2 +: 2] = sresp;
      step();
      s_bValid = '0;
      chk("wr_bvalid_after_slave", m_bValid, 1);
    end
    chk("wr_m_bResp", m_bResp, eresp);
    m_bReady = 1'b1;
    step();
    m_bReady = 1'b0;
    chk("wr_bvalid_drop", m_bValid, 0);
    chk("wr_awready_back", m_awReady, 1);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int slv, input logic [DW-1:0] sdata,
                         input logic [1:0] sresp, input logic [DW-1:0] edata,
                         input logic [1:0] eresp, input int hold);
    logic [N-1:0] oh;
    int n;
    oh = (slv >= 0) ? (N'(1) << slv) : '0;
    m_arAddr = addr; m_arProt = 3'b001; m_arValid = 1'b1;
    n = 0;
    while (!m_arReady && n < TMO) begin step(); n++; end
    tmo("ar_ready_wait", n);
    step();
    m_arValid = 1'b0;
    if (slv < 0) begin
      chk("rd_miss_rvalid_c1", m_rValid, 0);
      chk("rd_miss_no_s_arValid", s_arValid, 0);
      step();
      chk("rd_miss_rvalid_c2", m_rValid, 1);
    end else begin
      chk("rd_s_arValid", s_arValid, oh);
      chk("rd_s_arAddr", s_arAddr, addr);
      chk("rd_s_arProt", s_arProt, 3'b001);
      s_arReady = oh;
      step();
      s_arReady = '0;
      chk("rd_s_arValid_drop", s_arValid, 0);
      n = 0;
      while (s_rReady !== oh && n < TMO) begin step(); n++; end
      tmo("rd_s_rReady_wait", n);
      s_rValid = '1;
      s_rData = {2{32'hCCCC_CCCC}}; s_rData[slv*DW +: DW] = sdata;
      s_rResp = 4'b0101; s_rResp[slv*2 +: 2] = sresp;
      step();
      s_rValid = '0;
      n = 0;
      while (!m_rValid && n < TMO) begin step(); n++; end
      tmo("rd_m_rValid_wait", n);
    end
    chk("rd_m_rData", m_rData, edata);
    chk("rd_m_rResp", m_rResp, eresp);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("rd_hold_rValid", m_rValid, 1);
      chk("rd_hold_rData", m_rData, edata);
      chk("rd_hold_rResp", m_rResp, eresp);
      chk("rd_hold_arReady", m_arReady, 0);
    end
    m_rReady = 1'b1;
    step();
    m_rReady = 1'b0;
    chk("rd_rvalid_drop", m_rValid, 0);
    chk("rd_arready_back", m_arReady, 1);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          slv;
    logic [1:0]  sresp;
    logic [1:0]  eresp;
    logic [31:0] edata;
  } vec_t;

  vec_t tv[9];
  int   n;

  initial begin
    // slave 0 = 0x?..?0xxx, slave 1 = 0x?..?1xxx (only bits 15:12 compared), else miss
    tv[0] = '{1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 1,  2'b00, 2'b00, 32'h0};
    tv[1] = '{1'b1, 32'h0000_0010, 32'h1234_5678, 0,  2'b10, 2'b10, 32'h0};
    tv[2] = '{1'b1, 32'h0000_5000, 32'h5555_AAAA, -1, 2'b00, 2'b11, 32'h0};
    tv[3] = '{1'b0, 32'h0000_0FFC, 32'hA5A5_A5A5, 0,  2'b00, 2'b00, 32'hA5A5_A5A5};
    tv[4] = '{1'b0, 32'h0000_1FFC, 32'h0BAD_F00D, 1,  2'b10, 2'b10, 32'h0BAD_F00D};
    tv[5] = '{1'b0, 32'h0000_5000, 32'h1111_2222, -1, 2'b00, 2'b11, 32'h0};
    tv[6] = '{1'b1, 32'h0000_2000, 32'h0000_0001, -1, 2'b00, 2'b11, 32'h0};
    tv[7] = '{1'b0, 32'hFFFF_0ABC, 32'h7777_8888, 0,  2'b01, 2'b01, 32'h7777_8888};
    tv[8] = '{1'b1, 32'h0000_1FFF, 32'h0F0F_0F0F, 1,  2'b01, 2'b01, 32'h0};

    // reset state
    repeat (3) step();
    chk("rst_outputs_zero", {m_awReady, m_wReady, m_bValid, m_arReady, m_rValid, s_awValid,
        s_wValid, s_bReady, s_arValid, s_rReady, m_bResp, m_rResp}, 0);
    chk("rst_rData_zero", m_rData, 0);
    areset = 1'b0;
    chk("rst_awready_still_low", m_awReady, 0);
    step();
    chk("rst_awready_rise", m_awReady, 1);
    chk("rst_arready_rise", m_arReady, 1);

    for (int i = 0; i < 9; i++) begin
      if (tv[i].wr)
        do_write(tv[i].addr, tv[i].data, tv[i].slv, tv[i].sresp, tv[i].eresp);
      else
        do_read(tv[i].addr, tv[i].slv, tv[i].data, tv[i].sresp, tv[i].edata, tv[i].eresp, 0);
    end

    // W accepted by slave 0 one cycle before AW; single B pulse
    send_aw(32'h0000_0020);
    send_w(32'h0BB0_0001);
    s_wReady = 2'b01;
    step();
    s_wReady = '0;
    chk("ord_w_drop", s_wValid, 0);
    chk("ord_aw_held", s_awValid, 2'b01);
    chk("ord_bready_not_yet", s_bReady, 0);
    s_awReady = 2'b01;
    step();
    s_awReady = '0;
    chk("ord_aw_drop", s_awValid, 0);
    n = 0;
    while (s_bReady !== 2'b01 && n < TMO) begin step(); n++; end
    tmo("ord_bready_wait", n);
    m_bReady = 1'b1;
    s_bValid = 2'b01; s_bResp = 4'b0000;
    step();
    s_bValid = '0;
    chk("ord_bvalid_pulse", m_bValid, 1);
    chk("ord_bresp", m_bResp, 2'b00);
    step();
    chk("ord_bvalid_drop", m_bValid, 0);
    step(); step();
    chk("ord_single_pulse", {m_bValid, s_awValid, s_wValid}, 0);
    m_bReady = 1'b0;

    // master stalls R for 5 cycles
    do_read(32'h0000_0100, 0, 32'hFEED_FACE, 2'b00, 32'hFEED_FACE, 2'b00, 5);

    // concurrent write to slave 1 and read from slave 0
    fork
      do_write(32'h0000_1100, 32'hCAFE_F00D, 1, 2'b10, 2'b10);
      do_read(32'h0000_0200, 0, 32'h600D_D00D, 2'b00, 32'h600D_D00D, 2'b00, 0);
    join

    // reset while waiting for the slave write response
    send_aw(32'h0000_1008);
    send_w(32'h1357_9BDF);
    s_awReady = 2'b10; s_wReady = 2'b10;
    step();
    s_awReady = '0; s_wReady = '0;
    n = 0;
    while (s_bReady !== 2'b10 && n < TMO) begin step(); n++; end
    tmo("rst_bwait_reach", n);
    areset = 1'b1;
    step();
    chk("rst_mid_all_zero", {m_awReady, m_wReady, m_bValid, m_arReady, m_rValid, s_awValid,
        s_wValid, s_bReady, s_arValid, s_rReady, m_bResp, m_rResp}, 0);
    areset = 1'b0;
    step();
    chk("rst_mid_awready", m_awReady, 1);
    do_write(32'h0000_1010, 32'h2468_ACE0, 1, 2'b00, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
